// File: rtl/kbest_pkg.sv
// rtl/kbest_pkg.sv - shared constants, FSM encoding and symbol mapping for the K-best stage
//
// Purpose : common definitions imported by the K-best detector stage and its sorter.
// Contents: SYM_W         bits per PAM-4 symbol code
//           PED_SAT_ALL   all-ones word; sliced to WL bits it is the PED saturation value
//           kbest_state_t FSM state encoding (IDLE / EXPAND / DONE)
//           sym_lvl()     PAM-4 code to signed amplitude level
package kbest_pkg;

   localparam int SYM_W = 2;

   localparam logic [63:0] PED_SAT_ALL = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } kbest_state_t;

   // Gray-free natural map: 00 -> -3, 01 -> -1, 10 -> +1, 11 -> +3
   function automatic logic signed [2:0] sym_lvl(input logic [SYM_W-1:0] code);
      logic signed [2:0] lvl;
      case (code)
         2'b00:   lvl = -3'sd3;
         2'b01:   lvl = -3'sd1;
         2'b10:   lvl = 3'sd1;
         default: lvl = 3'sd3;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/kbest_insert_sorter.sv
// rtl/kbest_insert_sorter.sv - K-entry ascending insertion sorter of {valid, PED, PATH}
//
// Purpose : keeps the K lowest-PED candidates seen since the last clear, in ascending order.
//           One candidate may be inserted per clock. Ties keep the earlier candidate first.
// Ports   : clk          clock, rising edge
//           rst          asynchronous active-high reset (clears all entries)
//           clear        synchronous clear of all entries
//           cand_valid   insert cand_ped/cand_path this cycle
//           cand_ped     candidate PED (unsigned, WL bits)
//           cand_path    candidate path (PW bits)
//           sorted_ped   packed PEDs, entry j at [j*WL+:WL], entry 0 lowest
//           sorted_path  packed paths, entry j at [j*PW+:PW]
module kbest_insert_sorter #(
   parameter int K  = 4,
   parameter int WL = 16,
   parameter int PW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              cand_valid,
   input  logic [WL-1:0]     cand_ped,
   input  logic [PW-1:0]     cand_path,
   output logic [K*WL-1:0]   sorted_ped,
   output logic [K*PW-1:0]   sorted_path
);
   import kbest_pkg::*;

   localparam logic [WL-1:0] PED_CLR = PED_SAT_ALL[WL-1:0];

   logic [K-1:0]  ent_v;
   logic [WL-1:0] ent_ped  [K];
   logic [PW-1:0] ent_path [K];

   // Value each entry would take if everything shifts down by one
   logic [K-1:0]  up_v;
   logic [WL-1:0] up_ped  [K];
   logic [PW-1:0] up_path [K];

   logic [K-1:0]  gt;
   logic [K-1:0]  gt_prev;
   logic [K-1:0]  take_cand;
   logic [K-1:0]  take_up;

   // gt is monotone (all zeros then all ones) because entries stay sorted and
   // invalid entries only ever sit at the tail. Strict '>' lets earlier ties win.
   always_comb begin
      gt = '0;
      for (int j = 0; j < K; j++) begin
         gt[j] = !ent_v[j] || (ent_ped[j] > cand_ped);
      end
   end

   assign gt_prev   = gt << 1;
   assign take_cand = gt & ~gt_prev;
   assign take_up   = gt & gt_prev;
   assign up_v      = (ent_v << 1) | K'(1);

   for (genvar j = 0; j < K; j++) begin : g_ent
      if (j == 0) begin : g_head
         assign up_ped[j]  = cand_ped;
         assign up_path[j] = cand_path;
      end else begin : g_tail
         assign up_ped[j]  = ent_ped[j-1];
         assign up_path[j] = ent_path[j-1];
      end
      assign sorted_ped[j*WL +: WL]  = ent_ped[j];
      assign sorted_path[j*PW +: PW] = ent_path[j];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < K; j++) begin
            ent_v[j]    <= 1'b0;
            ent_ped[j]  <= PED_CLR;
            ent_path[j] <= '0;
         end
      end else if (clear) begin
         for (int j = 0; j < K; j++) begin
            ent_v[j]    <= 1'b0;
            ent_ped[j]  <= PED_CLR;
            ent_path[j] <= '0;
         end
      end else if (cand_valid) begin
         for (int j = 0; j < K; j++) begin
            if (take_cand[j]) begin
               ent_v[j]    <= 1'b1;
               ent_ped[j]  <= cand_ped;
               ent_path[j] <= cand_path;
            end else if (take_up[j]) begin
               ent_v[j]    <= up_v[j];
               ent_ped[j]  <= up_ped[j];
               ent_path[j] <= up_path[j];
            end
         end
      end
   end

endmodule

// File: rtl/kbest_detector_stage.sv
// rtl/kbest_detector_stage.sv - K-best tree-search stage with valid/ready handshakes
//
// Purpose : latches K parent paths and PEDs, expands each into its 4 PAM-4 children
//           (one child per cycle) and keeps the K lowest-PED children in sorted order.
// Ports   : clk, rst          clock (rising edge), asynchronous active-high reset
//           in_valid/in_ready input bundle handshake
//           Rarr              [0+:WL] diagonal, [(i+1)*WL+:WL] weight of parent symbol i
//           Y                 rotated receive sample for this layer
//           PATH_in           K parent paths, (N-1) symbols each, symbol 0 most recent
//           PED_in            K unsigned parent PEDs
//           out_valid/out_ready output bundle handshake
//           PATH_out          K survivor paths (N symbols each), entry 0 best
//           PED_out           K survivor PEDs, ascending
module kbest_detector_stage #(
   parameter int WL    = 16,
   parameter int FRAC  = 10,
   parameter int K     = 4,
   parameter int N     = 2,
   parameter int SYM_W = kbest_pkg::SYM_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N*WL-1:0]          Rarr,
   input  logic [WL-1:0]            Y,
   input  logic [K*(N-1)*SYM_W-1:0] PATH_in,
   input  logic [K*WL-1:0]          PED_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [K*N*SYM_W-1:0]     PATH_out,
   output logic [K*WL-1:0]          PED_out
);
   import kbest_pkg::*;

   localparam int EW  = WL + 4;          // error word, wide enough for Y - s - Rdiag*lvl
   localparam int PPW = (N-1)*SYM_W;     // parent path width
   localparam int CPW = N*SYM_W;         // child path width
   localparam int NC  = 4*K;             // candidates per bundle
   localparam int TW  = $clog2(NC);
   localparam logic [WL-1:0] PED_MAX = PED_SAT_ALL[WL-1:0];
   localparam logic [TW-1:0] T_LAST  = TW'(NC-1);

   kbest_state_t state, state_nxt;

   logic          accept;
   logic          last;
   logic          cand_valid;
   logic [TW-1:0] t;

   logic [N*WL-1:0]   rarr_q;
   logic [WL-1:0]     y_q;
   logic [K*PPW-1:0]  path_q;
   logic [K*WL-1:0]   ped_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept)    state_nxt = ST_EXPAND;
         ST_EXPAND: if (last)      state_nxt = ST_DONE;
         ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      cand_valid = 1'b0;
      case (state)
         ST_IDLE:   in_ready   = 1'b1;
         ST_EXPAND: cand_valid = 1'b1;
         ST_DONE:   out_valid  = 1'b1;
         default:   in_ready   = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign last   = (t == T_LAST);

   // ---------------- input latches and candidate counter ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rarr_q <= '0;
         y_q    <= '0;
         path_q <= '0;
         ped_q  <= '0;
         t      <= '0;
      end else if (accept) begin
         rarr_q <= Rarr;
         y_q    <= Y;
         path_q <= PATH_in;
         ped_q  <= PED_in;
         t      <= '0;
      end else if (state == ST_EXPAND) begin
         t <= t + 1'b1;
      end
   end

   // ---------------- PED datapath ----------------
   logic [TW-1:0]    p;
   logic [SYM_W-1:0] c;
   logic [PPW-1:0]   path_p;
   logic [WL-1:0]    ped_p;

   assign p = t >> 2;
   assign c = SYM_W'(t[1:0]);

   always_comb begin
      path_p = '0;
      ped_p  = '0;
      for (int k = 0; k < K; k++) begin
         if (p == TW'(k)) begin
            path_p = path_q[k*PPW +: PPW];
            ped_p  = ped_q[k*WL +: WL];
         end
      end
   end

   function automatic logic signed [EW-1:0] lvl_ext(input logic [SYM_W-1:0] code);
      logic signed [2:0] l;
      l = sym_lvl(code);
      return {{(EW-3){l[2]}}, l};
   endfunction

   logic signed [EW-1:0]   yx, dx, rx, s, e;
   logic signed [2*EW-1:0] e2;
   logic [2*EW-1:0]        esq, dsh;
   logic [WL-1:0]          d, ped_c;
   logic [WL:0]            ped_sum;
   logic [CPW-1:0]         cand_path;

   assign yx = {{(EW-WL){y_q[WL-1]}}, y_q};
   assign dx = {{(EW-WL){rarr_q[WL-1]}}, rarr_q[WL-1:0]};

   always_comb begin
      s  = '0;
      rx = '0;
      // Interference of the already-decided parent symbols
      for (int i = 0; i < N-1; i++) begin
         rx = {{(EW-WL){rarr_q[(i+2)*WL-1]}}, rarr_q[(i+1)*WL +: WL]};
         s  = s + rx * lvl_ext(path_p[i*SYM_W +: SYM_W]);
      end
      e   = yx - s - dx * lvl_ext(c);
      e2  = {{EW{e[EW-1]}}, e};
      esq = $unsigned(e2 * e2);
      dsh = esq >> FRAC;
      d   = (|dsh[2*EW-1:WL]) ? PED_MAX : dsh[WL-1:0];
      ped_sum = {1'b0, ped_p} + {1'b0, d};
      ped_c   = ped_sum[WL] ? PED_MAX : ped_sum[WL-1:0];
   end

   // New symbol lands in symbol 0; older symbols move up one slot
   assign cand_path = {path_p, c};

   kbest_insert_sorter #(
      .K  (K),
      .WL (WL),
      .PW (CPW)
   ) u_sorter (
      .clk         (clk),
      .rst         (rst),
      .clear       (accept),
      .cand_valid  (cand_valid),
      .cand_ped    (ped_c),
      .cand_path   (cand_path),
      .sorted_ped  (PED_out),
      .sorted_path (PATH_out)
   );

endmodule

// File: tb/tb_kbest_detector_stage.sv
// tb/tb_kbest_detector_stage.sv - self-checking bench for kbest_detector_stage
module tb_kbest_detector_stage;
   localparam int WL = 16, FRAC = 10, K = 4, N = 2, SYM_W = 2;
   localparam int PPW = (N-1)*SYM_W, CPW = N*SYM_W, NC = 4*K;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [N*WL-1:0]     Rarr;
   logic [WL-1:0]       Y;
   logic [K*PPW-1:0]    PATH_in;
   logic [K*WL-1:0]     PED_in;
   logic                out_valid;
   logic                out_ready;
   logic [K*CPW-1:0]    PATH_out;
   logic [K*WL-1:0]     PED_out;

   kbest_detector_stage #(
      .WL(WL), .FRAC(FRAC), .K(K), .N(N), .SYM_W(SYM_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Rarr(Rarr), .Y(Y), .PATH_in(PATH_in), .PED_in(PED_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .PATH_out(PATH_out), .PED_out(PED_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WL-1:0]  exp_ped  [K];
   logic [CPW-1:0] exp_path [K];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint lvl(input int code);
      return 2*code - 3;
   endfunction

   function automatic longint model_ped(input logic [N*WL-1:0] r, input logic [WL-1:0] y,
                                        input logic [K*PPW-1:0] pth, input logic [K*WL-1:0] pin,
                                        input int p, input int c);
      longint s, e, d, tot, rv, rd, yv;
      logic [WL-1:0] tmp;
      s = 0;
      for (int i = 0; i < N-1; i++) begin
         tmp = r[(i+1)*WL +: WL];
         rv  = longint'($signed(tmp));
         s  += rv * lvl(int'(pth[p*PPW + i*SYM_W +: SYM_W]));
      end
      tmp = r[0 +: WL];
      rd  = longint'($signed(tmp));
      yv  = longint'($signed(y));
      e   = yv - s - rd * lvl(c);
      d   = (e * e) / (longint'(1) << FRAC);
      if (d > 65535) d = 65535;
      tot = longint'(pin[p*WL +: WL]) + d;
      if (tot > 65535) tot = 65535;
      return tot;
   endfunction

   // Stable selection of the K smallest candidates in generation order
   task automatic compute_expected(input logic [N*WL-1:0] r, input logic [WL-1:0] y,
                                   input logic [K*PPW-1:0] pth, input logic [K*WL-1:0] pin);
      longint         cp    [NC];
      logic [CPW-1:0] cpath [NC];
      bit             used  [NC];
      logic [PPW-1:0] pp;
      logic [SYM_W-1:0] cc;
      int best;
      for (int i = 0; i < NC; i++) begin
         cp[i]    = model_ped(r, y, pth, pin, i/4, i%4);
         pp       = pth[(i/4)*PPW +: PPW];
         cc       = SYM_W'(i%4);
         cpath[i] = {pp, cc};
         used[i]  = 1'b0;
      end
      for (int k = 0; k < K; k++) begin
         best = -1;
         for (int i = 0; i < NC; i++)
            if (!used[i] && (best < 0 || cp[i] < cp[best])) best = i;
         used[best]  = 1'b1;
         exp_ped[k]  = WL'(cp[best]);
         exp_path[k] = cpath[best];
      end
   endtask

   function automatic logic [K*CPW-1:0] exp_path_packed();
      logic [K*CPW-1:0] v;
      for (int k = 0; k < K; k++) v[k*CPW +: CPW] = exp_path[k];
      return v;
   endfunction

   function automatic logic [K*WL-1:0] exp_ped_packed();
      logic [K*WL-1:0] v;
      for (int k = 0; k < K; k++) v[k*WL +: WL] = exp_ped[k];
      return v;
   endfunction

   // ---------------- output compare ----------------
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         for (int k = 0; k < K; k++) begin
            chk($sformatf("ped_out[%0d]", k), 64'(PED_out[k*WL +: WL]), 64'(exp_ped[k]));
            chk($sformatf("path_out[%0d]", k), 64'(PATH_out[k*CPW +: CPW]), 64'(exp_path[k]));
         end
         chk("in_ready_in_done", 64'(in_ready), 64'(0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_bundle(input logic [N*WL-1:0] r, input logic [WL-1:0] y,
                             input logic [K*PPW-1:0] pth, input logic [K*WL-1:0] pin,
                             input int hold, input bit junk);
      int n, lat;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", 64'(in_ready), 64'(1));
      compute_expected(r, y, pth, pin);
      Rarr = r; Y = y; PATH_in = pth; PED_in = pin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      Rarr     = $urandom;
      Y        = WL'($urandom);
      PATH_in  = PPW*K'($urandom);
      PED_in   = {$urandom, $urandom};
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("out_valid_latency", 64'(lat), 64'(NC));
      for (int h = 0; h < hold; h++) begin
         chk("in_ready_hold", 64'(in_ready), 64'(0));
         in_valid = (junk && h == 2);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("out_valid_before_release", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_after_release", 64'(in_ready), 64'(1));
      chk("out_valid_after_release", 64'(out_valid), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      Rarr = '0; Y = '0; PATH_in = '0; PED_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_ped_out", PED_out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_path_out", 64'(PATH_out), 64'(0));
      rst = 1'b0;

      // Unit diagonal, Y = +1: code 10 is exact for every parent, ties in parent order
      run_bundle(32'h0000_0400, 16'd1024, 8'hE4, 64'd0, 0, 1'b0);
      chk("t1_model_path", 64'(exp_path_packed()), 64'h0000_0000_0000_EA62);
      chk("t1_model_ped", 64'(exp_ped_packed()), 64'd0);

      // Zero channel: only parent 0 (PED 0) contributes survivors
      run_bundle(32'h0, 16'd0, 8'hE4, {16'd300, 16'd200, 16'd100, 16'd0}, 1, 1'b0);
      chk("t2_model_path", 64'(exp_path_packed()), 64'h0000_0000_0000_3210);
      chk("t2_model_ped", 64'(exp_ped_packed()), 64'd0);

      // Saturation: huge error and large parent PED must clamp, never wrap
      run_bundle(32'h0000_0400, 16'h8000, 8'hE4, {4{16'd65000}}, 0, 1'b0);
      chk("t3_model_ped", 64'(exp_ped_packed()), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_model_path", 64'(exp_path_packed()), 64'h0000_0000_0000_3210);

      // Off-diagonal only: parent symbol +3 cancels Y, parent symbol -3 gives e=6144
      run_bundle(32'h0400_0000, 16'd3072, 8'h93, 64'd0, 0, 1'b0);
      chk("t4_model_d_parent1", 64'(model_ped(32'h0400_0000, 16'd3072, 8'h93, 64'd0, 1, 0)),
          64'd36864);
      chk("t4_model_path", 64'(exp_path_packed()), 64'h0000_0000_0000_FEDC);

      // Back-pressure: 10 cycles of hold with an ignored in_valid pulse
      run_bundle($urandom, WL'($urandom), 8'($urandom), {$urandom, $urandom}, 10, 1'b1);

      // Reset in the middle of EXPAND (t = 7)
      @(negedge clk);
      Rarr = 32'h0000_0400; Y = 16'd1024; PATH_in = 8'hE4; PED_in = 64'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'(0));
      chk("midreset_ped_out", PED_out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("midreset_path_out", 64'(PATH_out), 64'(0));
      chk("midreset_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      run_bundle(32'h0123_0456, 16'h0789, 8'h1B, {16'd40, 16'd30, 16'd20, 16'd10}, 0, 1'b0);

      // Randomised bundles, mixing small and full-range parent PEDs
      for (int it = 0; it < 30; it++) begin
         logic [K*WL-1:0] pin;
         for (int k = 0; k < K; k++)
            pin[k*WL +: WL] = (it % 2 == 0) ? WL'($urandom_range(0, 2000))
                                            : WL'($urandom_range(0, 65535));
         run_bundle($urandom, WL'($urandom), 8'($urandom), pin,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kbest_detector_stage.md
# kbest_detector_stage

Parametrised K-best tree-search stage for the real-valued 4x4 16-QAM MIMO detector: accepts K surviving partial paths with their partial Euclidean distances (PEDs), expands each into the 4 PAM-4 children of the current layer, and keeps the K lowest-PED children in sorted order. It replaces the fixed-K, always-flowing detector stage. It adds valid/ready handshakes on both sides, so that stages of any layer index N can be chained behind the path generator.

## Interface
- WL, 16, fixed-point word length of R, Y, PED
- FRAC, 10, fractional bits of R and Y (Q(WL-FRAC-1).FRAC)
- K, 4, survivors in and out (K>=1)
- N, 2, layers decided after this stage (N>=2; layer 1 is produced by the path generator)
- SYM_W, 2, bits per PAM-4 symbol code
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept a bundle
- Rarr  in  N*WL  signed; [0+:WL] is the diagonal, [(i+1)*WL+:WL] multiplies parent symbol i
- Y  in  WL  signed rotated receive sample for this layer
- PATH_in  in  K*(N-1)*SYM_W  parent paths; entry k at [k*(N-1)*SYM_W+:], symbol i at [i*SYM_W+:SYM_W] within the entry, symbol 0 = most recent layer
- PED_in  in  K*WL  unsigned parent PEDs, entry k at [k*WL+:WL]
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- PATH_out  out  K*N*SYM_W  survivors; entry 0 has the best PED
- PED_out  out  K*WL  unsigned survivor PEDs, ascending

## Operation
- Symbol map: code 00→-3, 01→-1, 10→+1, 11→+3.
- FSM states are IDLE, EXPAND and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch Rarr, Y, PATH_in and PED_in, clear the sorter, and go to EXPAND with t=0.
- EXPAND: one candidate per cycle, t=0..4K-1, parent p=t/4, child code c=t%4.
  - s = Σ_i Rarr_i·lvl(sym_i(p)) (exact, no shift).
  - e = Y − s − Rdiag·lvl(c), signed WL+4 bits, no overflow.
  - d = (e·e)>>FRAC, saturated to 2^WL−1.
  - PED = PED_in[p]+d, saturated to 2^WL−1.
  - Child path = {PATH_in[p], c}: the new symbol goes to symbol 0 and older symbols shift up.
  - After t=4K−1, go to DONE.
- Sorter: K entries, each {valid, PED, PATH}, kept ascending.
  - A candidate is inserted at the first position whose PED is strictly greater, or whose entry is invalid; lower entries shift down and the last entry drops.
  - On ties, the earlier candidate wins, giving order by (PED, parent index, code).
  - Cleared entries hold PED=2^WL−1, PATH=0, valid=0.
- DONE: out_valid=1, with PATH_out/PED_out driven from the sorter. On out_ready, go to IDLE. While waiting, outputs stay stable and in_ready=0.
- in_valid is ignored outside IDLE.
- Reset, including mid-EXPAND or mid-DONE: state=IDLE, in_ready=1, out_valid=0, PATH_out=0, PED_out all ones (sorter cleared). Any partial work is discarded.

## Timing
- Accept edge is cycle 0. Candidates are inserted on edges 1..4K. out_valid rises after edge 4K and is visible in cycle 4K.
- The earliest next accept is one cycle after the output handshake. Minimum initiation interval is 4K+2 cycles.
- PED datapath is combinational from the latched registers into the sorter, with one insertion per cycle. Registered outputs come straight from the sorter.

## Structure
- Package kbest_pkg:
  - symbol-to-level function
  - SYM_W
  - PED saturation constant
  - FSM state encoding
- Sub-module kbest_insert_sorter (params K, WL, PW): cand_valid, cand_ped, cand_path, clear; outputs the packed sorted list.
- The top level contains the FSM, input latches, the t counter and the PED datapath.

## Test plan
All scenarios use K=4, N=2, FRAC=10.
- Rdiag=1024, off=0, Y=1024, PED_in=0, parents 00/01/10/11 -> PED_out={0,0,0,0}, PATH_out entries {00,10},{01,10},{10,10},{11,10} in parent order (tie rule); out_valid is observed in cycle 16.
- R=0, Y=0, PED_in={0,100,200,300} -> survivors are all children of parent 0: codes 00,01,10,11, each with PED 0.
- Rdiag=1024, Y=-32768, off=0, PED_in=65000 -> every PED saturates to 65535, with no wrap.
- Off-diag=1024, Rdiag=0, Y=3072, parent symbols {11,00,...} -> parent 0 children have PED 0 and rank first, and parent 1 children have d=36864 (e=6144).
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Releasing out_ready gives in_ready=1 on the next cycle.
- Assert rst at EXPAND t=7 -> out_valid=0 and PED_out=65535 immediately. The next bundle yields correct results with no stale entries.
